// File: rtl/arm_trace_monitor_if.sv
// rtl/arm_trace_monitor_if.sv - processor sample inputs and trace stream bundle
interface arm_trace_monitor_if #(
  parameter int DEPTH = 8
) ();
  logic                     EN;
  logic                     CLEAR;
  logic [31:0]              Instr;
  logic [31:0]              ALUResult;
  logic [1:0]               ALUControl;
  logic                     TR_VALID;
  logic                     TR_READY;
  logic [31:0]              TR_INSTR;
  logic [31:0]              TR_ALU;
  logic [1:0]               TR_CTRL;
  logic [15:0]              TR_IDX;
  logic                     HALTED;
  logic                     OVERFLOW;
  logic [15:0]              INSTR_CNT;
  logic [$clog2(DEPTH):0]   LEVEL;

  modport master (
    output EN, CLEAR, Instr, ALUResult, ALUControl, TR_READY,
    input  TR_VALID, TR_INSTR, TR_ALU, TR_CTRL, TR_IDX,
    input  HALTED, OVERFLOW, INSTR_CNT, LEVEL
  );

  modport slave (
    input  EN, CLEAR, Instr, ALUResult, ALUControl, TR_READY,
    output TR_VALID, TR_INSTR, TR_ALU, TR_CTRL, TR_IDX,
    output HALTED, OVERFLOW, INSTR_CNT, LEVEL
  );
endinterface

// File: rtl/arm_trace_monitor.sv
// rtl/arm_trace_monitor.sv - captures processor instruction samples into a trace FIFO
module arm_trace_monitor #(
  parameter int          DEPTH      = 8,
  parameter logic [31:0] HALT_INSTR = 32'hE0000000
) (
  input  logic                CLK,
  input  logic                RST,
  arm_trace_monitor_if.slave  bus
);

  localparam int             AW       = $clog2(DEPTH);
  localparam int             EW       = 82;
  localparam logic [AW:0]    LVL_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     level_q, level_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [EW-1:0]   mem_q [DEPTH];
  logic [EW-1:0]   mem_d [DEPTH];

  logic            sample_ev;
  logic            pop;
  logic            push;
  logic [EW-1:0]   head;

  // Next-state logic: FSM, FIFO pointers/occupancy, counter and sticky overflow.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    cnt_d      = cnt_q;
    mem_d      = mem_q;

    // A halt word is never a sample; IDLE behaves like RUN for the enabling cycle.
    sample_ev = bus.EN && (state_q != S_HALT) && (bus.Instr != HALT_INSTR);
    pop       = (level_q != '0) && bus.TR_READY;
    // A full FIFO still accepts when the head leaves in the same cycle.
    push      = sample_ev && ((level_q != LVL_FULL) || pop);

    if (bus.CLEAR) begin
      state_d    = S_IDLE;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      overflow_d = 1'b0;
      cnt_d      = '0;
    end else begin
      if (bus.EN && (state_q != S_HALT)) begin
        state_d = (bus.Instr == HALT_INSTR) ? S_HALT : S_RUN;
      end
      if (sample_ev) begin
        cnt_d = cnt_q + 16'd1;
        if (!push) begin
          overflow_d = 1'b1;
        end
      end
      if (push) begin
        mem_d[wr_ptr_q] = {bus.Instr, bus.ALUResult, bus.ALUControl, cnt_q};
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // State registers with asynchronous reset discarding all trace contents.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      cnt_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      cnt_q      <= cnt_d;
      mem_q      <= mem_d;
    end
  end

  // Head fields read zero whenever the FIFO is empty.
  always_comb begin
    head = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
  end

  assign bus.TR_VALID  = (level_q != '0);
  assign bus.TR_INSTR  = head[81:50];
  assign bus.TR_ALU    = head[49:18];
  assign bus.TR_CTRL   = head[17:16];
  assign bus.TR_IDX    = head[15:0];
  assign bus.HALTED    = (state_q == S_HALT);
  assign bus.OVERFLOW  = overflow_q;
  assign bus.INSTR_CNT = cnt_q;
  assign bus.LEVEL     = level_q;

endmodule

// File: tb/tb_arm_trace_monitor.sv
// tb/tb_arm_trace_monitor.sv - scoreboard bench for arm_trace_monitor
module tb_arm_trace_monitor;

  localparam int          DEPTH = 8;
  localparam logic [31:0] HALT  = 32'hE0000000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] alu;
    logic [1:0]  ctrl;
    logic [15:0] idx;
  } entry_t;

  logic clk;
  logic rst_n;

  arm_trace_monitor_if #(.DEPTH(DEPTH)) bus ();

  arm_trace_monitor #(.DEPTH(DEPTH), .HALT_INSTR(HALT)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  entry_t      sb[$];
  int          m_state = 0;
  logic [15:0] m_cnt   = '0;
  logic        m_ovf   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_state = 0;
    m_cnt   = '0;
    m_ovf   = 1'b0;
  endtask

  // One clock cycle: drive at the falling edge, compare, update model, advance.
  task automatic cyc(input logic en, input logic [31:0] instr, input logic ready,
                     input logic clr = 1'b0);
    entry_t e;
    logic   m_pop;
    bus.EN         = en;
    bus.Instr      = instr;
    bus.ALUResult  = $urandom;
    bus.ALUControl = 2'($urandom_range(3));
    bus.TR_READY   = ready;
    bus.CLEAR      = clr;
    #1;
    check("level",    32'(bus.LEVEL), 32'(sb.size()));
    check("tr_valid", 32'(bus.TR_VALID), 32'(sb.size() != 0));
    check("halted",   32'(bus.HALTED), 32'(m_state == 2));
    check("overflow", 32'(bus.OVERFLOW), 32'(m_ovf));
    check("instr_cnt", 32'(bus.INSTR_CNT), 32'(m_cnt));
    if (sb.size() != 0) begin
      check("tr_instr", bus.TR_INSTR, sb[0].instr);
      check("tr_alu",   bus.TR_ALU, sb[0].alu);
      check("tr_ctrl",  32'(bus.TR_CTRL), 32'(sb[0].ctrl));
      check("tr_idx",   32'(bus.TR_IDX), 32'(sb[0].idx));
    end
    m_pop = !clr && (sb.size() != 0) && ready;
    if (m_pop) void'(sb.pop_front());
    if (clr) begin
      model_reset();
    end else if (en && m_state != 2) begin
      if (instr == HALT) begin
        m_state = 2;
      end else begin
        m_state = 1;
        e = '{instr: instr, alu: bus.ALUResult, ctrl: bus.ALUControl, idx: m_cnt};
        if (sb.size() < DEPTH) sb.push_back(e);
        else m_ovf = 1'b1;
        m_cnt = m_cnt + 16'd1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_instr();
    return $urandom | 32'h1;
  endfunction

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) cyc(1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.EN         = 1'b0;
    bus.CLEAR      = 1'b0;
    bus.Instr      = '0;
    bus.ALUResult  = '0;
    bus.ALUControl = '0;
    bus.TR_READY   = 1'b0;
    #3;
    check("rst_level",    32'(bus.LEVEL), 32'd0);
    check("rst_valid",    32'(bus.TR_VALID), 32'd0);
    check("rst_halted",   32'(bus.HALTED), 32'd0);
    check("rst_overflow", 32'(bus.OVERFLOW), 32'd0);
    check("rst_cnt",      32'(bus.INSTR_CNT), 32'd0);
    check("rst_tr_instr", bus.TR_INSTR, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Three instructions with an always-ready consumer.
    cyc(1'b1, 32'hE3A00005, 1'b1);
    cyc(1'b1, 32'hE2801001, 1'b1);
    cyc(1'b1, 32'hE0812002, 1'b1);
    drain();
    check("basic_cnt", 32'(bus.INSTR_CNT), 32'd3);
    check("basic_ovf", 32'(bus.OVERFLOW), 32'd0);

    // Overflow: ten samples into an eight-entry FIFO with no consumer.
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) cyc(1'b1, rnd_instr(), 1'b0);
    check("ovf_level", 32'(bus.LEVEL), 32'd8);
    check("ovf_flag",  32'(bus.OVERFLOW), 32'd1);
    check("ovf_cnt",   32'(bus.INSTR_CNT), 32'd10);
    for (int i = 0; i < DEPTH; i++) begin
      check("ovf_drain_idx", 32'(bus.TR_IDX), 32'(i));
      cyc(1'b0, 32'h0, 1'b1);
    end
    check("ovf_empty", 32'(bus.LEVEL), 32'd0);

    // Push accepted into a full FIFO when the head pops in the same cycle.
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, rnd_instr(), 1'b0);
    cyc(1'b1, rnd_instr(), 1'b1);
    check("full_pp_level", 32'(bus.LEVEL), 32'd8);
    check("full_pp_ovf",   32'(bus.OVERFLOW), 32'd0);
    drain();

    // Halt after four instructions; later samples ignored, drain continues.
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, rnd_instr(), 1'b0);
    cyc(1'b1, HALT, 1'b0);
    check("halt_flag", 32'(bus.HALTED), 32'd1);
    check("halt_cnt",  32'(bus.INSTR_CNT), 32'd4);
    for (int i = 0; i < 3; i++) cyc(1'b1, rnd_instr(), 1'b0);
    check("halt_level", 32'(bus.LEVEL), 32'd4);
    for (int i = 0; i < 4; i++) cyc(1'b1, rnd_instr(), 1'b1);
    check("halt_drained", 32'(bus.LEVEL), 32'd0);
    check("halt_cnt2",    32'(bus.INSTR_CNT), 32'd4);
    cyc(1'b1, rnd_instr(), 1'b0, 1'b1);
    check("clr_halted", 32'(bus.HALTED), 32'd0);
    check("clr_cnt",    32'(bus.INSTR_CNT), 32'd0);

    // Asynchronous reset with five entries held.
    for (int i = 0; i < 5; i++) cyc(1'b1, rnd_instr(), 1'b0);
    check("pre_rst_level", 32'(bus.LEVEL), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_level", 32'(bus.LEVEL), 32'd0);
    check("arst_valid", 32'(bus.TR_VALID), 32'd0);
    check("arst_cnt",   32'(bus.INSTR_CNT), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, rnd_instr(), 1'b0);
    check("post_rst_idx", 32'(bus.TR_IDX), 32'd0);
    drain();

    // Counter wrap after 65536 samples.
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 65536; i++) cyc(1'b1, rnd_instr(), 1'b1);
    drain();
    check("wrap_cnt", 32'(bus.INSTR_CNT), 32'd0);
    cyc(1'b1, rnd_instr(), 1'b0);
    check("wrap_idx", 32'(bus.TR_IDX), 32'd0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/arm_trace_monitor.md
ARM_TRACE_MONITOR -- requirements
Module: arm_trace_monitor

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8 (power of two, 2..64), trace FIFO entries.
REQ-002 The block SHALL have parameter HALT_INSTR, default 32'hE0000000, the end-of-program instruction word.
REQ-003 CLK  input  1  sole clock, all state updates on rising edge.
REQ-004 RST  input  1  asynchronous, active-low reset.
REQ-005 EN  input  1  capture enable; processor instruction valid this cycle.
REQ-006 CLEAR  input  1  synchronous flush of FIFO, counters, flags.
REQ-007 Instr  input  32  current processor instruction.
REQ-008 ALUResult  input  32  current ALU result.
REQ-009 ALUControl  input  2  current ALU control.
REQ-010 TR_VALID  output  1  FIFO head entry available.
REQ-011 TR_READY  input  1  consumer accepts head entry.
REQ-012 TR_INSTR / TR_ALU / TR_CTRL / TR_IDX  output  32/32/2/16  head entry fields.
REQ-013 HALTED  output  1  halt instruction seen.
REQ-014 OVERFLOW  output  1  sticky, entry dropped on full FIFO.
REQ-015 INSTR_CNT  output  16  instructions captured or dropped since reset/CLEAR.
REQ-016 LEVEL  output  log2(DEPTH)+1  current FIFO occupancy.

Function
REQ-017 FSM SHALL have states IDLE, RUN, HALT; IDLE->RUN on first cycle EN=1 (that cycle's sample SHALL be processed as in RUN).
REQ-018 In RUN with EN=1 and Instr!=HALT_INSTR, a sample event {Instr, ALUResult, ALUControl, INSTR_CNT} SHALL occur and INSTR_CNT SHALL increment by 1, wrapping 16'hFFFF->0.
REQ-019 In RUN (or IDLE) with EN=1 and Instr==HALT_INSTR, the block SHALL enter HALT, assert HALTED next cycle, and SHALL NOT push or count that instruction.
REQ-020 In RUN with EN=0 no push, no count, state unchanged.
REQ-021 In HALT no further samples SHALL be pushed or counted; FIFO draining SHALL continue; HALT exits only via RST or CLEAR.
REQ-022 A sample event SHALL push when LEVEL<DEPTH, or when LEVEL==DEPTH and a pop occurs the same cycle; otherwise the sample SHALL be dropped and OVERFLOW set (sticky).
REQ-023 Pop SHALL occur on TR_VALID=1 and TR_READY=1; TR_* fields SHALL hold stable while TR_VALID=1 and TR_READY=0.
REQ-024 TR_VALID SHALL equal (LEVEL!=0); a push into an empty FIFO SHALL raise TR_VALID the next cycle (no fall-through).
REQ-025 Simultaneous push and pop SHALL leave LEVEL unchanged; entries SHALL be delivered in capture order.
REQ-026 TR_IDX SHALL equal INSTR_CNT value before increment for that sample.
REQ-027 CLEAR=1 SHALL, next edge, empty FIFO, zero INSTR_CNT, clear HALTED and OVERFLOW, go IDLE; CLEAR overrides push/pop that cycle.

Reset
REQ-028 RST=0 SHALL immediately force state IDLE, LEVEL=0, TR_VALID=0, HALTED=0, OVERFLOW=0, INSTR_CNT=0, TR_* fields=0, independent of CLK.
REQ-029 RST asserted mid-operation SHALL discard all FIFO contents; first sample after RST release SHALL carry TR_IDX=0.

Verification
REQ-030 Reset, TR_READY=1, EN=1, 3 instrs E3A00005,E2801001,E0812002 -> three entries TR_IDX 0,1,2 in order, INSTR_CNT=3, OVERFLOW=0.
REQ-031 TR_READY=0, DEPTH=8, 10 non-halt instrs -> LEVEL=8, OVERFLOW=1, INSTR_CNT=10, later drain yields TR_IDX 0..7.
REQ-032 FIFO full, TR_READY=1 and EN=1 same cycle -> push accepted, LEVEL stays 8, OVERFLOW stays 0.
REQ-033 Instr=E0000000 with EN=1 after 4 instrs -> HALTED=1 next cycle, INSTR_CNT=4, subsequent EN=1 samples ignored, 4 entries drained.
REQ-034 RST=0 asynchronously mid-stream with LEVEL=5 -> LEVEL=0, TR_VALID=0 before next edge; CLEAR in HALT -> IDLE, HALTED=0, INSTR_CNT=0.
REQ-035 INSTR_CNT preset via 65536 samples (TR_READY=1) -> wraps to 0, next TR_IDX=0.
